// File: rtl/block_miner.sv
// block_miner: proof-of-work stage between the game controller and the blockchain RAM
//   clock           in   rising-edge system clock
//   resetn          in   asynchronous active-low reset
//   start           in   request a mining run, honoured only while idle
//   ram_result      in   RAM read data for the slot chosen by ram_access_type
//   ram_access_type out  0 selects the transaction word, 1 the previous-hash slot
//   ram_wren        out  RAM write strobe, only while storing the winning hash
//   ram_data_out    out  RAM write data, {40'b0, hash_out}
//   busy            out  high whenever the miner is not idle
//   done            out  one-cycle end-of-run pulse
//   fail            out  valid with done, 1 when every nonce failed
//   hash_out        out  hash of the last attempt
//   nonce_out       out  nonce of the last attempt, zero-extended
module block_miner #(
  parameter int DIFFICULTY = 2,
  parameter int NONCE_W    = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [47:0] ram_result,
  output logic        ram_access_type,
  output logic        ram_wren,
  output logic [47:0] ram_data_out,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [7:0]  hash_out,
  output logic [7:0]  nonce_out
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_PREV = 3'd1;
  localparam logic [2:0] RD_TX   = 3'd2;
  localparam logic [2:0] HASH    = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] WRITE   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [7:0] NONCE_MAX = 8'((1 << NONCE_W) - 1);
  localparam int         SHIFT     = 8 - DIFFICULTY;
  logic [2:0]  state_q, state_d;
  logic [7:0]  prev_q, prev_d;
  logic [47:0] tx_q, tx_d;
  logic [7:0]  h_q, h_d;
  logic [7:0]  nonce_q, nonce_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  hash_q, hash_d;
  logic [7:0]  nonce_out_q, nonce_out_d;
  logic        fail_q, fail_d;
  logic        pass;
  logic [7:0]  nonce_inc;
  // only the top DIFFICULTY bits survive the shift
  assign pass      = (h_q >> SHIFT) == 8'd0;
  assign nonce_inc = nonce_q + 8'd1;
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    tx_d        = tx_q;
    h_d         = h_q;
    nonce_d     = nonce_q;
    cnt_d       = cnt_q;
    hash_d      = hash_q;
    nonce_out_d = nonce_out_q;
    fail_d      = fail_q;
    case (state_q)
      IDLE: begin
        nonce_d = start ? 8'd0 : nonce_q;
        state_d = start ? RD_PREV : IDLE;
      end
      RD_PREV: begin
        prev_d  = ram_result[7:0];
        state_d = RD_TX;
      end
      RD_TX: begin
        tx_d    = ram_result;
        h_d     = prev_q ^ nonce_q;
        cnt_d   = 3'd0;
        state_d = HASH;
      end
      HASH: begin
        h_d     = {h_q[6:0], h_q[7]} + tx_q[8*cnt_q +: 8];
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd5) ? CHECK : HASH;
      end
      CHECK: begin
        hash_d      = h_q;
        nonce_out_d = nonce_q;
        if (pass) begin
          state_d = WRITE;
        end else if (nonce_q != NONCE_MAX) begin
          // next attempt restarts from the latched prev; RAM is not re-read
          nonce_d = nonce_inc;
          h_d     = prev_q ^ nonce_inc;
          cnt_d   = 3'd0;
          state_d = HASH;
        end else begin
          fail_d  = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        fail_d  = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      tx_q        <= '0;
      h_q         <= '0;
      nonce_q     <= '0;
      cnt_q       <= '0;
      hash_q      <= '0;
      nonce_out_q <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tx_q        <= tx_d;
      h_q         <= h_d;
      nonce_q     <= nonce_d;
      cnt_q       <= cnt_d;
      hash_q      <= hash_d;
      nonce_out_q <= nonce_out_d;
      fail_q      <= fail_d;
    end
  end
  // hash_q equals h during WRITE, so the write data can come straight from it
  assign ram_access_type = (state_q == RD_PREV) || (state_q == WRITE);
  assign ram_wren        = state_q == WRITE;
  assign ram_data_out    = {40'b0, hash_q};
  assign busy            = state_q != IDLE;
  assign done            = state_q == DONE;
  assign fail            = fail_q;
  assign hash_out        = hash_q;
  assign nonce_out       = nonce_out_q;
endmodule

// File: tb/tb_block_miner.sv
// tb_block_miner: directed checks of block_miner with three parameterisations and a RAM model each
module tb_block_miner;
  logic clock = 1'b0;
  logic resetn;
  logic start0, start1, start2;
  logic [47:0] rr0, rr1, rr2, dout0, dout1, dout2;
  logic acc0, acc1, acc2, wren0, wren1, wren2;
  logic busy0, busy1, busy2, done0, done1, done2, fail0, fail1, fail2;
  logic [7:0] hash0, hash1, hash2, nonce0, nonce1, nonce2;
  logic [47:0] m0, m1, m2, lv0, lv1, lv2;
  logic ld;
  int tests = 0;
  int fails = 0;
  localparam logic [47:0] TX0 = 48'h0;
  localparam logic [47:0] TX1 = 48'h1;
  localparam logic [47:0] TX2 = 48'h0;
  always #5 clock = ~clock;
  block_miner u0 (.clock(clock), .resetn(resetn), .start(start0), .ram_result(rr0),
    .ram_access_type(acc0), .ram_wren(wren0), .ram_data_out(dout0), .busy(busy0),
    .done(done0), .fail(fail0), .hash_out(hash0), .nonce_out(nonce0));
  block_miner #(.DIFFICULTY(1)) u1 (.clock(clock), .resetn(resetn), .start(start1), .ram_result(rr1),
    .ram_access_type(acc1), .ram_wren(wren1), .ram_data_out(dout1), .busy(busy1),
    .done(done1), .fail(fail1), .hash_out(hash1), .nonce_out(nonce1));
  block_miner #(.DIFFICULTY(4), .NONCE_W(2)) u2 (.clock(clock), .resetn(resetn), .start(start2), .ram_result(rr2),
    .ram_access_type(acc2), .ram_wren(wren2), .ram_data_out(dout2), .busy(busy2),
    .done(done2), .fail(fail2), .hash_out(hash2), .nonce_out(nonce2));
  assign rr0 = acc0 ? m0 : TX0;
  assign rr1 = acc1 ? m1 : TX1;
  assign rr2 = acc2 ? m2 : TX2;
  always @(posedge clock) begin
    if (ld) begin
      m0 <= lv0;
      m1 <= lv1;
      m2 <= lv2;
    end else begin
      if (wren0) m0 <= dout0;
      if (wren1) m1 <= dout1;
      if (wren2) m2 <= dout2;
    end
  end
  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_u0_zero(input string tag);
    chk1({tag, "_busy"}, busy0, 1'b0);
    chk1({tag, "_done"}, done0, 1'b0);
    chk1({tag, "_fail"}, fail0, 1'b0);
    chk1({tag, "_wren"}, wren0, 1'b0);
    chk1({tag, "_acc"}, acc0, 1'b0);
    chk48({tag, "_dout"}, dout0, 48'h0);
    chk8({tag, "_hash"}, hash0, 8'h0);
    chk8({tag, "_nonce"}, nonce0, 8'h0);
  endtask
  task automatic load_ram();
    @(negedge clock);
    ld = 1'b1;
    @(negedge clock);
    ld = 1'b0;
  endtask
  // prev=FF tx=0, defaults: nonces 0..2 fail, nonce 3 gives 3F; WRITE at 31, done at 32
  task automatic run_s1(input bit pulses);
    @(negedge clock);
    chk1("s1_busy_c0", busy0, 1'b0);
    start0 = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clock);
      start0 = pulses && (c == 5 || c == 31);
      chk1("s1_busy", busy0, c <= 32);
      chk1("s1_acc", acc0, c == 1 || c == 31);
      chk1("s1_wren", wren0, c == 31);
      chk1("s1_done", done0, c == 32);
      if (c == 31) chk48("s1_dout", dout0, 48'h3F);
      if (c == 32) begin
        chk8("s1_hash", hash0, 8'h3F);
        chk8("s1_nonce", nonce0, 8'h03);
        chk1("s1_fail", fail0, 1'b0);
      end
    end
    start0 = 1'b0;
    chk48("s1_ram_prev", m0, 48'h3F);
  endtask
  initial begin
    resetn = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    ld = 1'b0;
    lv0 = 48'hFF;
    lv1 = 48'h0;
    lv2 = 48'hFF;
    repeat (2) @(negedge clock);
    chk_u0_zero("rst");
    chk1("rst_busy2", busy2, 1'b0);
    load_ram();
    resetn = 1'b1;
    run_s1(1'b1);
    // u1: prev=0 tx=1 D=1 -> 0x20 on first nonce; u2: NONCE_W=2 D=4 exhausts at cycle 31
    @(negedge clock);
    start1 = 1'b1;
    start2 = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clock);
      start1 = 1'b0;
      start2 = 1'b0;
      chk1("s2_busy", busy1, c <= 11);
      chk1("s2_acc", acc1, c == 1 || c == 10);
      chk1("s2_wren", wren1, c == 10);
      chk1("s2_done", done1, c == 11);
      chk1("s3_busy", busy2, c <= 31);
      chk1("s3_acc", acc2, c == 1);
      chk1("s3_wren", wren2, 1'b0);
      chk1("s3_done", done2, c == 31);
      if (c == 11) begin
        chk8("s2_hash", hash1, 8'h20);
        chk8("s2_nonce", nonce1, 8'h00);
        chk1("s2_fail", fail1, 1'b0);
      end
      if (c == 31 || c == 33) begin
        chk1("s3_fail", fail2, 1'b1);
        chk8("s3_hash", hash2, 8'h3F);
        chk8("s3_nonce", nonce2, 8'h03);
      end
    end
    chk48("s2_ram_prev", m1, 48'h20);
    chk48("s3_ram_prev", m2, 48'hFF);
    // start held high: second run starts the cycle after DONE+1, then reset mid-HASH
    lv1 = 48'h20;
    load_ram();
    start0 = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 38; c++) begin
      @(negedge clock);
      chk1("s4_busy", busy0, c <= 32 || c >= 34);
      chk1("s4_acc", acc0, c == 1 || c == 31 || c == 34);
      chk1("s4_wren", wren0, c == 31);
      chk1("s4_done", done0, c == 32);
      if (c == 32) chk8("s4_hash", hash0, 8'h3F);
    end
    start0 = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_u0_zero("s5_rst");
    chk48("s5_ram_prev", m0, 48'h3F);
    @(negedge clock);
    resetn = 1'b1;
    load_ram();
    run_s1(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/block_miner.md
# block_miner

Proof-of-work stage that sits directly in front of the blockchain RAM. On `start` it reads the stored previous hash and the 48-bit transaction word from the RAM, then searches nonces for an 8-bit hash with `DIFFICULTY` leading zero bits. On success it writes the winning hash back into the RAM's previous-hash slot. It reports the hash, the nonce, and success or failure to the game controller.

## Interface
Parameters:
- `DIFFICULTY`, default 2: number of hash MSBs that must be zero (1..8).
- `NONCE_W`, default 8: nonce width (1..8), zero-extended to 8 bits when used.

Ports:
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a mining run; sampled only in IDLE.
- `ram_result`  in  48  RAM read data; combinational from `ram_access_type`.
- `ram_access_type`  out  1  0 = transaction word, 1 = previous hash.
- `ram_wren`  out  1  RAM write strobe.
- `ram_data_out`  out  48  RAM write data, equal to {40'b0, hash_out}.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `fail`  out  1  valid with `done`: 1 means nonce space exhausted, no write.
- `hash_out`  out  8  last computed hash; holds until the next run.
- `nonce_out`  out  8  nonce of the last attempt, zero-extended.

## Operation
Hash for one attempt:
- Init: h = prev ^ nonce.
- For i = 0..5, one byte per cycle: h = rotl1(h) + tx[8i+7:8i], mod 256. Byte 0 is tx[7:0].
- Pass condition: h[7:8-DIFFICULTY] == 0.

State machine:
- IDLE: if `start`, clear nonce, go to RD_PREV. Otherwise stay.
- RD_PREV: drive `ram_access_type`=1. Latch `ram_result[7:0]` into prev at the end of the cycle. Go to RD_TX.
- RD_TX: drive `ram_access_type`=0. Latch `ram_result` into tx. Init h. Go to HASH.
- HASH: 6 cycles, one byte per cycle, byte counter 0..5. Go to CHECK.
- CHECK: register h into `hash_out` and nonce into `nonce_out`.
  - Pass: go to WRITE.
  - Fail with nonce < 2^NONCE_W-1: nonce+1, re-init h, go to HASH.
  - Fail with nonce == 2^NONCE_W-1: set `fail`, go to DONE.
- WRITE: `ram_access_type`=1, `ram_wren`=1, `ram_data_out`={40'b0,h}. Clear `fail`. Go to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.

Rules:
- `ram_wren` is high only in WRITE, so the transaction word is never written.
- `start` outside IDLE is ignored; no queueing.
- `start` held high re-triggers on the cycle after DONE.
- The nonce never wraps past 2^NONCE_W-1.

## Timing
- Reset (async, immediate): state IDLE, and every output is 0 (`busy`, `done`, `fail`, `ram_wren`, `ram_access_type`, `ram_data_out`, `hash_out`, `nonce_out`). Internal prev, tx, h, nonce and counter are also cleared.
- Cycle 0 is the edge that samples `start`. RD_PREV is cycle 1 and RD_TX is cycle 2.
- Each attempt takes 7 cycles (6 HASH + CHECK).
- Success on attempt k (k = 1..2^NONCE_W): WRITE at cycle 2+7k+1, `done` at cycle 2+7k+2.
- Exhaustion after N = 2^NONCE_W attempts: `done` at cycle 2+7N+1.
- `busy` rises at cycle 1 and falls the cycle after DONE.
- `hash_out`, `nonce_out` and `fail` are stable from DONE until the next run's first CHECK.
- Reset mid-run aborts immediately with no RAM write. If reset asserts during WRITE, the RAM is reset by the same signal anyway.

## Test plan
- Reset with RAM prev=0xFF, tx=0. Pulse `start` (defaults) -> nonce 0..2 fail. CHECK 4 gives `hash_out`=0x3F, `nonce_out`=3. `ram_wren` high at cycle 31, `done` at cycle 32, `fail`=0. RAM prev reads 0x3F afterwards.
- prev=0x00, tx=0x000000000001, DIFFICULTY=1 -> hash 0x20, nonce 0. WRITE at cycle 10, `done` at cycle 11.
- NONCE_W=2, DIFFICULTY=4, prev=0xFF, tx=0 -> 4 failing attempts. `done` at cycle 31 with `fail`=1, `ram_wren` never high, RAM prev still 0xFF.
- `start` pulses during HASH and during WRITE -> ignored, exactly one `done`. `start` held high -> new run, `busy` at the cycle after DONE+1.
- Assert `resetn`=0 mid-HASH of the first scenario -> all outputs 0 immediately, no `ram_wren`. After release, a new `start` reproduces the first scenario's results.
- Check `ram_access_type` is 1 in RD_PREV and WRITE and 0 elsewhere. Check `busy` is high exactly from cycle 1 through DONE.
